// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game constants and state encoding. Used by the
//                sequencer and by the renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Game state encoding, also decoded by the renderer
    typedef enum logic [2:0] {
        S_RUNNING    = 3'd0,
        S_GAME_OVER  = 3'd1,
        S_WIN        = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_IDLE       = 3'd4
    } game_state_t;

    // Geometry is held at 12 bits so that sums of 10-bit coordinates never wrap
    localparam logic [11:0] c_sprite_size  = 12'd16;
    localparam logic [11:0] c_goal_x_min   = 12'd580;  // player_x + 16 must exceed this
    localparam logic [11:0] c_goal_x_max   = 12'd630;  // player_x must not exceed this
    localparam logic [11:0] c_goal_y_min   = 12'd355;  // player_y + 16 lower bound (inclusive)
    localparam logic [11:0] c_goal_y_max   = 12'd360;  // player_y + 16 upper bound (inclusive)
    localparam logic [11:0] c_lava_floor_y = 12'd380;
    localparam logic [11:0] c_lava_col_x   = 12'd270;
    localparam logic [11:0] c_lava_col_w   = 12'd40;
    localparam logic [11:0] c_wall_w       = 12'd10;
    localparam logic [11:0] c_screen_h     = 12'd480;
    localparam logic [10:0] c_wall_x_max   = 11'd629;

endpackage : game_pkg
`default_nettype wire

// File: rtl/lava_rise_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lava_rise_timer
//  Description : Counts enabled frame ticks and emits a one-cycle rise pulse
//                on every RISE_DIV-th one.
//  Revision    : 1.0 - initial release
// ============================================================================
module lava_rise_timer #(
    parameter int RISE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic rise
);

    localparam int c_cnt_w = (RISE_DIV > 1) ? $clog2(RISE_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RISE_DIV - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == c_last);
    assign rise   = enable && tick && w_wrap;

    // Frame counter: cleared on level start, wraps after RISE_DIV enabled ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && tick) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule : lava_rise_timer
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Frame-driven game state machine: level progression, advancing
//                lava wall, rising lava column, death/goal detection and
//                player respawn pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int WALL_SPEED0  = 1,
    parameter int WALL_SPEED1  = 2,
    parameter int WALL_SPEED2  = 3,
    parameter int RISE_DIV     = 4,
    parameter int LAVA_MAX     = 200,
    parameter int INTER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [2:0] game_state,
    output logic [1:0] level,
    output logic [9:0] lava_wall_x,
    output logic [9:0] lava_height,
    output logic       player_reset
);

    localparam int c_inter_w = (INTER_FRAMES > 1) ? $clog2(INTER_FRAMES) : 1;
    localparam logic [c_inter_w-1:0] c_inter_load = c_inter_w'(INTER_FRAMES - 1);
    localparam logic [9:0] c_lava_max = 10'(LAVA_MAX);

    game_state_t          r_state, w_state_nxt;
    logic [1:0]           r_level, w_level_nxt;
    logic [9:0]           r_wall, w_wall_nxt;
    logic [9:0]           r_lava, w_lava_nxt;
    logic [c_inter_w-1:0] r_inter, w_inter_nxt;
    logic                 r_player_reset, w_player_reset_nxt;

    logic [11:0] w_px, w_py, w_wall12, w_lava12;
    logic        w_death, w_goal;
    logic [10:0] w_speed, w_wall_sum;
    logic [9:0]  w_wall_step, w_lava_step;
    logic        w_rise, w_rise_en, w_rise_clear;

    assign w_px     = {2'b00, player_x};
    assign w_py     = {2'b00, player_y};
    assign w_wall12 = {2'b00, r_wall};
    assign w_lava12 = {2'b00, r_lava};

    // Death: touching the wall, below the lava floor, or inside the lava column
    assign w_death = (w_px < w_wall12 + c_wall_w)
                  || (w_py + c_sprite_size > c_lava_floor_y)
                  || ((w_px + c_sprite_size > c_lava_col_x)
                      && (w_px < c_lava_col_x + c_lava_col_w)
                      && (w_py + c_sprite_size + w_lava12 > c_screen_h));

    // Goal: sprite overlaps the goal rectangle
    assign w_goal = (w_px + c_sprite_size > c_goal_x_min)
                 && (w_px <= c_goal_x_max)
                 && (w_py + c_sprite_size >= c_goal_y_min)
                 && (w_py + c_sprite_size <= c_goal_y_max);

    // Per-level wall speed
    always_comb begin
        w_speed = 11'(WALL_SPEED2);
        case (r_level)
            2'd0:    w_speed = 11'(WALL_SPEED0);
            2'd1:    w_speed = 11'(WALL_SPEED1);
            default: w_speed = 11'(WALL_SPEED2);
        endcase
    end

    assign w_wall_sum  = {1'b0, r_wall} + w_speed;
    assign w_wall_step = (w_wall_sum > c_wall_x_max) ? c_wall_x_max[9:0] : w_wall_sum[9:0];
    assign w_lava_step = (r_lava < c_lava_max) ? r_lava + 10'd1 : r_lava;

    // Rise counter runs only on uneventful running frames
    assign w_rise_en    = (r_state == S_RUNNING) && !w_death && !w_goal;
    assign w_rise_clear = (start_btn && (r_state == S_IDLE || r_state == S_GAME_OVER || r_state == S_WIN))
                       || (frame_tick && (r_state == S_LEVEL_DONE) && (r_inter == '0));

    lava_rise_timer #(
        .RISE_DIV (RISE_DIV)
    ) u_rise_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_rise_clear),
        .enable (w_rise_en),
        .tick   (frame_tick),
        .rise   (w_rise)
    );

    // Next-state and next-register computation
    always_comb begin
        w_state_nxt        = r_state;
        w_level_nxt        = r_level;
        w_wall_nxt         = r_wall;
        w_lava_nxt         = r_lava;
        w_inter_nxt        = r_inter;
        w_player_reset_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (start_btn) begin
                    w_state_nxt        = S_RUNNING;
                    w_level_nxt        = 2'd0;
                    w_wall_nxt         = '0;
                    w_lava_nxt         = '0;
                    w_inter_nxt        = '0;
                    w_player_reset_nxt = 1'b1;
                end
            end
            S_RUNNING: begin
                if (frame_tick) begin
                    if (w_death) begin
                        w_state_nxt = S_GAME_OVER;
                    end else if (w_goal) begin
                        if (r_level == 2'd2) begin
                            w_state_nxt = S_WIN;
                        end else begin
                            w_state_nxt = S_LEVEL_DONE;
                            w_inter_nxt = c_inter_load;
                        end
                    end else begin
                        w_wall_nxt = w_wall_step;
                        if (w_rise) begin
                            w_lava_nxt = w_lava_step;
                        end
                    end
                end
            end
            S_LEVEL_DONE: begin
                if (frame_tick) begin
                    if (r_inter == '0) begin
                        w_state_nxt        = S_RUNNING;
                        w_level_nxt        = r_level + 2'd1;
                        w_wall_nxt         = '0;
                        w_lava_nxt         = '0;
                        w_player_reset_nxt = 1'b1;
                    end else begin
                        w_inter_nxt = r_inter - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_level        <= 2'd0;
            r_wall         <= '0;
            r_lava         <= '0;
            r_inter        <= '0;
            r_player_reset <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_level        <= w_level_nxt;
            r_wall         <= w_wall_nxt;
            r_lava         <= w_lava_nxt;
            r_inter        <= w_inter_nxt;
            r_player_reset <= w_player_reset_nxt;
        end
    end

    assign game_state   = r_state;
    assign level        = r_level;
    assign lava_wall_x  = r_wall;
    assign lava_height  = r_lava;
    assign player_reset = r_player_reset;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Scoreboard bench for game_sequencer. Stimulus pushes expected
//                snapshots and respawn levels; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic [9:0] player_x = 10'd100;
    logic [9:0] player_y = 10'd100;
    logic [2:0] game_state;
    logic [1:0] level;
    logic [9:0] lava_wall_x;
    logic [9:0] lava_height;
    logic       player_reset;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [9:0] wall;
        logic [9:0] lava;
        logic       pr;
    } snap_t;

    snap_t      snap_q[$];
    string      name_q[$];
    logic [1:0] rs_q[$];

    game_sequencer #(
        .WALL_SPEED0  (1),
        .WALL_SPEED1  (2),
        .WALL_SPEED2  (3),
        .RISE_DIV     (4),
        .LAVA_MAX     (200),
        .INTER_FRAMES (120)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .player_x     (player_x),
        .player_y     (player_y),
        .game_state   (game_state),
        .level        (level),
        .lava_wall_x  (lava_wall_x),
        .lava_height  (lava_height),
        .player_reset (player_reset)
    );

    always #5 clk = ~clk;

    // Monitor: compares queued snapshots and every respawn pulse at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                automatic snap_t s  = snap_q.pop_front();
                automatic string nm = name_q.pop_front();
                checks++;
                if (game_state !== s.st || level !== s.lv || lava_wall_x !== s.wall
                    || lava_height !== s.lava || player_reset !== s.pr) begin
                    errors++;
                    $display("FAIL %s: got state=%0d level=%0d wall=%0d lava=%0d preset=%0b, expected state=%0d level=%0d wall=%0d lava=%0d preset=%0b",
                             nm, game_state, level, lava_wall_x, lava_height, player_reset,
                             s.st, s.lv, s.wall, s.lava, s.pr);
                end
            end
            if (player_reset === 1'b1) begin
                checks++;
                if (rs_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_respawn: got player_reset=1 at level=%0d, expected no pulse", level);
                end else begin
                    automatic logic [1:0] lv = rs_q.pop_front();
                    if (level !== lv) begin
                        errors++;
                        $display("FAIL respawn_level: got level=%0d, expected level=%0d", level, lv);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_snap(input string nm, input logic [2:0] st, input logic [1:0] lv,
                               input logic [9:0] wall, input logic [9:0] lava, input logic pr);
        snap_t s;
        s.st = st; s.lv = lv; s.wall = wall; s.lava = lava; s.pr = pr;
        snap_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
    endtask

    task automatic set_player(input int x, input int y);
        player_x = 10'(x);
        player_y = 10'(y);
    endtask

    // Goal on the current level then sit through the intermission
    task automatic goal_advance(input logic [1:0] next_lv);
        set_player(590, 340);
        tick_n(1);
        set_player(100, 100);
        rs_q.push_back(next_lv);
        tick_n(120);
    endtask

    initial begin
        cyc(3);
        expect_snap("reset_state", S_IDLE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        tick_n(3);
        expect_snap("idle_ignores_tick", S_IDLE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);

        // Start and single-cycle respawn pulse
        rs_q.push_back(2'd0);
        press_start();
        expect_snap("start_pulse", S_RUNNING, 2'd0, 10'd0, 10'd0, 1'b1);
        cyc(1);
        expect_snap("start_pulse_one_clk", S_RUNNING, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);

        // Goal at level 0, intermission, start ignored, advance
        set_player(590, 340);
        tick_n(1);
        expect_snap("goal_level0", S_LEVEL_DONE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);
        press_start();
        expect_snap("start_ignored_level_done", S_LEVEL_DONE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);
        set_player(100, 100);
        tick_n(119);
        expect_snap("intermission_hold", S_LEVEL_DONE, 2'd0, 10'd0, 10'd0, 1'b0);
        rs_q.push_back(2'd1);
        tick_n(1);
        expect_snap("advance_level1", S_RUNNING, 2'd1, 10'd0, 10'd0, 1'b0);

        // Level 1 wall and lava progress
        tick_n(10);
        expect_snap("level1_10frames", S_RUNNING, 2'd1, 10'd20, 10'd2, 1'b0);

        // Floor death while x overlaps goal; registers freeze
        set_player(590, 370);
        tick_n(1);
        expect_snap("floor_death", S_GAME_OVER, 2'd1, 10'd20, 10'd2, 1'b0);
        tick_n(5);
        expect_snap("game_over_frozen", S_GAME_OVER, 2'd1, 10'd20, 10'd2, 1'b0);

        // Restart and climb to level 2
        rs_q.push_back(2'd0);
        press_start();
        expect_snap("restart_from_game_over", S_RUNNING, 2'd0, 10'd0, 10'd0, 1'b1);
        cyc(1);
        goal_advance(2'd1);
        goal_advance(2'd2);
        expect_snap("reach_level2", S_RUNNING, 2'd2, 10'd0, 10'd0, 1'b0);

        // Saturation with player far from every hazard
        set_player(1000, 100);
        tick_n(700);
        expect_snap("wall_saturated", S_RUNNING, 2'd2, 10'd629, 10'd175, 1'b0);
        tick_n(150);
        expect_snap("lava_saturated", S_RUNNING, 2'd2, 10'd629, 10'd200, 1'b0);

        // Wall death and goal in the same frame: death wins
        set_player(600, 340);
        tick_n(1);
        expect_snap("wall_death_over_goal", S_GAME_OVER, 2'd2, 10'd629, 10'd200, 1'b0);
        cyc(1);

        // Win on level 2
        rs_q.push_back(2'd0);
        press_start();
        cyc(1);
        goal_advance(2'd1);
        goal_advance(2'd2);
        set_player(590, 340);
        tick_n(1);
        expect_snap("win_level2", S_WIN, 2'd2, 10'd0, 10'd0, 1'b0);
        tick_n(3);
        expect_snap("win_frozen", S_WIN, 2'd2, 10'd0, 10'd0, 1'b0);
        rs_q.push_back(2'd0);
        press_start();
        expect_snap("restart_from_win", S_RUNNING, 2'd0, 10'd0, 10'd0, 1'b1);
        cyc(1);

        // Asynchronous reset in the middle of an intermission
        set_player(590, 340);
        tick_n(51);
        expect_snap("mid_intermission", S_LEVEL_DONE, 2'd0, 10'd0, 10'd0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_snap("async_reset", S_IDLE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(2);
        frame_tick = 1'b1;
        rst = 1'b0;
        cyc(1);
        frame_tick = 1'b0;
        expect_snap("after_reset_release", S_IDLE, 2'd0, 10'd0, 10'd0, 1'b0);
        cyc(1);
        set_player(100, 100);
        rs_q.push_back(2'd0);
        press_start();
        expect_snap("restart_after_reset", S_RUNNING, 2'd0, 10'd0, 10'd0, 1'b1);
        cyc(3);

        checks++;
        if (rs_q.size() != 0) begin
            errors++;
            $display("FAIL respawn_missing: got %0d pending respawn pulses, expected 0", rs_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_game_sequencer
`default_nettype wire
